// File: rtl/jtag_dbg_pkg.sv
// jtag_dbg_pkg: TAP state encodings, debug instruction codes and CTRL/STATUS bit positions
package jtag_dbg_pkg;
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_IDLE         = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam int INS_IDCODE = 1;
    localparam int INS_ADDR   = 2;
    localparam int INS_DATA   = 3;
    localparam int INS_CTRL   = 4;
    localparam int INS_MODE   = 5;
    localparam int INS_STATUS = 6;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_STEP    = 1;
    localparam int CTRL_AUTOINC = 2;
    localparam int CTRL_CLR_ERR = 3;

    localparam int STAT_RDATA_VALID = 0;
    localparam int STAT_HALTED      = 1;
    localparam int STAT_BUSY        = 2;
    localparam int STAT_ERROR       = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 TAP state machine exporting one-hot capture/shift/update strobes
module jtag_tap_fsm
    import jtag_dbg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tms,
    output logic tlr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr
);
    tap_state_e state, next;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= TEST_LOGIC_RESET;
        else     state <= next;

    always_comb begin
        next = state;
        case (state)
            TEST_LOGIC_RESET: next = tms ? TEST_LOGIC_RESET : RUN_IDLE;
            RUN_IDLE:         next = tms ? SELECT_DR : RUN_IDLE;
            SELECT_DR:        next = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       next = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         next = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         next = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         next = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         next = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        next = tms ? SELECT_DR : RUN_IDLE;
            SELECT_IR:        next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       next = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         next = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         next = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         next = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         next = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        next = tms ? SELECT_DR : RUN_IDLE;
        endcase
    end

    assign tlr        = state == TEST_LOGIC_RESET;
    assign capture_ir = state == CAPTURE_IR;
    assign shift_ir   = state == SHIFT_IR;
    assign update_ir  = state == UPDATE_IR;
    assign capture_dr = state == CAPTURE_DR;
    assign shift_dr   = state == SHIFT_DR;
    assign update_dr  = state == UPDATE_DR;
endmodule

// File: rtl/jtag_dbg_tap.sv
// jtag_dbg_tap: JTAG TAP with IDCODE/BYPASS and a debug-bus memory-access engine
// with auto-increment, sticky error and CPU run/step control, all clocked on TCK.
module jtag_dbg_tap
    import jtag_dbg_pkg::*;
#(
    parameter int          IR_WIDTH   = 5,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5F
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  TDO_EN,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  rd_wr,
    output logic                  req,
    input  logic                  ack,
    output logic                  step,
    output logic                  run,
    input  logic                  halted
);
    localparam int SW = max3(32, ADDR_WIDTH, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;
    logic [IR_WIDTH-1:0] ir_sr, instr;
    logic [SW-1:0] dr_sr, dr_cap, dr_next;
    logic [3:0] ctrl_cap, stat_cap;
    int dr_len;
    logic auto_inc, error, rdata_valid;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic is_addr, is_data, is_ctrl, is_mode;

    jtag_tap_fsm u_fsm (
        .clk(TCK), .rst(TRST), .tms(TMS), .tlr(tlr),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr)
    );

    assign is_addr = instr == IR_WIDTH'(INS_ADDR);
    assign is_data = instr == IR_WIDTH'(INS_DATA);
    assign is_ctrl = instr == IR_WIDTH'(INS_CTRL);
    assign is_mode = instr == IR_WIDTH'(INS_MODE);

    always_comb begin
        ctrl_cap = '0;
        ctrl_cap[CTRL_AUTOINC] = auto_inc;
        ctrl_cap[CTRL_RUN] = run;
        stat_cap = '0;
        stat_cap[STAT_ERROR] = error;
        stat_cap[STAT_BUSY] = req;
        stat_cap[STAT_HALTED] = halted;
        stat_cap[STAT_RDATA_VALID] = rdata_valid;
        dr_len = 1;
        dr_cap = '0;
        case (instr)
            IR_WIDTH'(INS_IDCODE): begin dr_len = 32;         dr_cap = SW'(IDCODE_VAL); end
            IR_WIDTH'(INS_ADDR):   begin dr_len = ADDR_WIDTH; dr_cap = SW'(address);    end
            IR_WIDTH'(INS_DATA):   begin dr_len = DATA_WIDTH; dr_cap = SW'(rdata_q);    end
            IR_WIDTH'(INS_CTRL):   begin dr_len = 4;          dr_cap = SW'(ctrl_cap);   end
            IR_WIDTH'(INS_MODE):   begin dr_len = 1;          dr_cap = SW'(rd_wr);      end
            IR_WIDTH'(INS_STATUS): begin dr_len = 4;          dr_cap = SW'(stat_cap);   end
            default:               begin dr_len = 1;          dr_cap = '0;              end
        endcase
        // captured values are zero-extended, so bits above the selected length stay clear
        dr_next = (dr_sr >> 1) | (SW'(TDI) << (dr_len - 1));
    end

    always_ff @(posedge TCK or posedge TRST)
        if (TRST) begin
            ir_sr <= '0;
            instr <= IR_WIDTH'(INS_IDCODE);
            dr_sr <= '0;
        end else begin
            ir_sr <= capture_ir ? IR_WIDTH'(1) : shift_ir ? {TDI, ir_sr[IR_WIDTH-1:1]} : ir_sr;
            instr <= tlr ? IR_WIDTH'(INS_IDCODE) : update_ir ? ir_sr : instr;
            dr_sr <= capture_dr ? dr_cap : shift_dr ? dr_next : dr_sr;
        end

    always_ff @(posedge TCK or posedge TRST)
        if (TRST) begin
            address     <= '0;
            data_out    <= '0;
            rd_wr       <= 1'b0;
            req         <= 1'b0;
            step        <= 1'b0;
            run         <= 1'b0;
            auto_inc    <= 1'b0;
            error       <= 1'b0;
            rdata_q     <= '0;
            rdata_valid <= 1'b0;
        end else begin
            step <= update_dr && is_ctrl && dr_sr[CTRL_STEP];
            if (update_dr && is_ctrl) begin
                run      <= dr_sr[CTRL_RUN];
                auto_inc <= dr_sr[CTRL_AUTOINC];
                if (dr_sr[CTRL_CLR_ERR]) error <= 1'b0;
            end
            // req doubles as the busy flag: anything that would disturb an access is dropped
            if (update_dr && (is_addr || is_data || is_mode) && req) error <= 1'b1;
            if (update_dr && is_addr && !req) address <= dr_sr[ADDR_WIDTH-1:0];
            if (update_dr && is_mode && !req) rd_wr <= dr_sr[0];
            if (update_dr && is_data && !req) begin
                req <= 1'b1;
                if (rd_wr) data_out <= dr_sr[DATA_WIDTH-1:0];
            end
            if (capture_dr && is_data) rdata_valid <= 1'b0;
            if (req && ack) begin
                req <= 1'b0;
                if (!rd_wr) begin
                    rdata_q     <= data_in;
                    rdata_valid <= 1'b1;
                end
                if (auto_inc) address <= address + INC;
            end
        end

    always_ff @(negedge TCK or posedge TRST)
        if (TRST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO    <= (shift_ir && ir_sr[0]) || (shift_dr && dr_sr[0]);
            TDO_EN <= shift_ir || shift_dr;
        end
endmodule

// File: tb/tb_jtag_dbg_tap.sv
// tb_jtag_dbg_tap: randomized scoreboard bench; scans and bus requests are checked
// by independent monitors against a register-level model of the debug port.
module tb_jtag_dbg_tap;
    localparam logic [31:0] IDC = 32'h1000_0A5F;

    logic TCK = 0, TRST = 1, TMS = 1, TDI = 0, ack = 0, halted = 0;
    logic TDO, TDO_EN, rd_wr, req, step, run;
    logic [31:0] address, data_out, data_in = 0;
    int passed = 0, total = 0;

    int m_instr;
    logic [31:0] m_addr, m_dout, m_rdata;
    bit m_rdwr, m_auto, m_run, m_err, m_rdv, m_busy;

    int exp_len[$];
    logic [63:0] exp_val[$];
    string exp_name[$];
    logic [31:0] bus_addr[$], bus_data[$];
    bit bus_wr[$];
    logic [31:0] rd_data[$];
    int exp_steps = 0;
    bit ack_hold = 0;
    int ack_delay = 3;

    always #5 TCK = ~TCK;

    jtag_dbg_tap #(.IR_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32), .IDCODE_VAL(IDC)) dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .address(address), .data_out(data_out), .data_in(data_in), .rd_wr(rd_wr),
        .req(req), .ack(ack), .step(step), .run(run), .halted(halted)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] mask(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    task automatic model_reset();
        m_instr = 1; m_addr = 0; m_dout = 0; m_rdata = 0;
        m_rdwr = 0; m_auto = 0; m_run = 0; m_err = 0; m_rdv = 0; m_busy = 0;
    endtask

    task automatic model_reg(output int len, output logic [63:0] cap);
        case (m_instr)
            1:       begin len = 32; cap = 64'(IDC); end
            2:       begin len = 32; cap = 64'(m_addr); end
            3:       begin len = 32; cap = 64'(m_rdata); end
            4:       begin len = 4;  cap = {60'b0, 1'b0, m_auto, 1'b0, m_run}; end
            5:       begin len = 1;  cap = 64'(m_rdwr); end
            6:       begin len = 4;  cap = {60'b0, m_err, m_busy, halted, m_rdv}; end
            default: begin len = 1;  cap = 0; end
        endcase
    endtask

    task automatic model_update(input logic [63:0] upd);
        case (m_instr)
            2: if (m_busy) m_err = 1; else m_addr = upd[31:0];
            3: if (m_busy) m_err = 1;
               else begin
                   if (m_rdwr) m_dout = upd[31:0];
                   bus_addr.push_back(m_addr); bus_data.push_back(m_dout); bus_wr.push_back(m_rdwr);
                   m_busy = 1;
               end
            4: begin
                   m_auto = upd[2]; m_run = upd[0];
                   if (upd[1]) exp_steps++;
                   if (upd[3]) m_err = 0;
               end
            5: if (m_busy) m_err = 1; else m_rdwr = upd[0];
            default: ;
        endcase
    endtask

    task automatic tck(input logic tms, input logic tdi);
        TMS = tms; TDI = tdi;
        @(posedge TCK); #1;
        @(negedge TCK);
    endtask

    task automatic ir_scan(input int code);
        exp_len.push_back(5); exp_val.push_back(64'd1); exp_name.push_back("ir capture");
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        for (int i = 0; i < 5; i++) tck(i == 4, code[i]);
        tck(1, 0); tck(0, 0);
        m_instr = code;
    endtask

    task automatic dr_scan(input logic [31:0] v, input int nbits = 0);
        int len, n;
        logic [63:0] cap, stream;
        model_reg(len, cap);
        n = (nbits == 0) ? len : nbits;
        stream = ({32'b0, v} << len) | cap;
        exp_len.push_back(n);
        exp_val.push_back(stream & mask(n));
        exp_name.push_back($sformatf("dr ir=%0d", m_instr));
        if (m_instr == 3) m_rdv = 0;
        tck(1, 0); tck(0, 0); tck(0, 0);
        for (int i = 0; i < n; i++) tck(i == n - 1, v[i]);
        model_update((stream >> n) & mask(len));
        tck(1, 0); tck(0, 0);
        if (m_instr == 4) check("run level", run, m_run);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (m_busy && i < 60) begin tck(0, 0); i++; end
        if (m_busy) begin total++; $display("FAIL idle: access not acked after %0d TCKs", i); end
        tck(0, 0);
    endtask

    // scan monitor: gathers TDO while TDO_EN is high and compares each finished scan
    initial begin
        int n = 0;
        logic [63:0] v = 0;
        forever begin
            @(posedge TCK); #1;
            if (TDO_EN) begin
                if (n < 64) v[n] = TDO;
                n++;
            end else if (n > 0) begin
                if (exp_len.size() == 0) begin
                    total++;
                    $display("FAIL scan: unexpected %0d-bit scan got %h expected none", n, v);
                end else begin
                    string nm;
                    nm = exp_name.pop_front();
                    check({nm, " length"}, 64'(n), 64'(exp_len.pop_front()));
                    check({nm, " tdo"}, v, exp_val.pop_front());
                end
                n = 0; v = 0;
            end
        end
    end

    initial begin
        int len = 0;
        forever begin
            @(posedge TCK); #1;
            if (step) len++;
            else if (len > 0) begin
                if (exp_steps == 0) begin
                    total++;
                    $display("FAIL step: unexpected pulse of %0d TCKs expected none", len);
                end else begin
                    exp_steps--;
                    check("step width", 64'(len), 64'd1);
                end
                len = 0;
            end
        end
    end

    // bus monitor and responder: checks requests against the model, acks after ack_delay
    initial begin
        bit prev = 0, ew = 0;
        int cnt = 0;
        logic [31:0] ea = 0, ed = 0;
        forever begin
            @(posedge TCK); #1;
            if (req && !prev) begin
                cnt = 0;
                if (bus_addr.size() == 0) begin
                    total++;
                    $display("FAIL bus req: unexpected request addr=%h expected none", address);
                end else begin
                    ea = bus_addr.pop_front(); ed = bus_data.pop_front(); ew = bus_wr.pop_front();
                    check("req address", address, ea);
                    check("req data_out", data_out, ed);
                    check("req rd_wr", rd_wr, ew);
                end
            end
            if (req) cnt++;
            if (req && !ack_hold && cnt >= ack_delay) begin
                check("hold address", address, ea);
                check("hold data_out", data_out, ed);
                check("hold rd_wr", rd_wr, ew);
                data_in = (rd_data.size() > 0) ? rd_data.pop_front() : $urandom;
                ack = 1;
                @(posedge TCK);
                m_busy = 0;
                if (!ew) begin m_rdata = data_in; m_rdv = 1; end
                if (m_auto) m_addr += 4;
                #1 ack = 0;
                check("req drop after ack", req, 0);
            end
            prev = req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge TCK);
        check("reset TDO", TDO, 0);
        check("reset TDO_EN", TDO_EN, 0);
        check("reset address", address, 0);
        check("reset data_out", data_out, 0);
        check("reset rd_wr", rd_wr, 0);
        check("reset req", req, 0);
        check("reset step", step, 0);
        check("reset run", run, 0);
        TRST = 0;
        tck(0, 0);
        dr_scan($urandom);

        ir_scan(6);
        begin
            int len;
            logic [63:0] cap;
            model_reg(len, cap);
            exp_len.push_back(1); exp_val.push_back(cap & 1); exp_name.push_back("partial status");
        end
        tck(1, 0); tck(0, 0); tck(0, 0);
        repeat (5) tck(1, 0);
        m_instr = 1;
        tck(0, 0);
        dr_scan($urandom);

        ir_scan(31);
        dr_scan(32'hA5, 8);

        ir_scan(2); dr_scan(32'h100);
        ir_scan(5); dr_scan(1);
        ir_scan(3); dr_scan(32'hDEAD_BEEF);
        wait_idle();

        ir_scan(4); dr_scan(32'b0100);
        ir_scan(5); dr_scan(0);
        rd_data.push_back(32'h11); rd_data.push_back(32'h22);
        ir_scan(3); dr_scan($urandom); wait_idle();
        dr_scan($urandom); wait_idle();
        dr_scan($urandom); wait_idle();
        ir_scan(6); dr_scan(0);
        ir_scan(2); dr_scan(32'hFFFF_FFFC);
        ir_scan(3); dr_scan(0); wait_idle();
        ir_scan(2); dr_scan(32'h200);

        ack_hold = 1;
        ir_scan(3); dr_scan($urandom);
        dr_scan($urandom);
        ir_scan(6); dr_scan(0);
        ir_scan(5); dr_scan(1);
        ack_hold = 0;
        wait_idle();
        ir_scan(6); dr_scan(0);
        ir_scan(4); dr_scan(32'b1000);
        ir_scan(6); dr_scan(0);

        for (int it = 0; it < 10; it++) begin
            halted = 1'($urandom_range(0, 1));
            ack_delay = $urandom_range(1, 5);
            case ($urandom_range(0, 4))
                0: begin ir_scan(2); dr_scan($urandom); end
                1: begin ir_scan(5); dr_scan(32'($urandom_range(0, 1))); end
                2: begin ir_scan(3); dr_scan($urandom); wait_idle(); end
                3: begin ir_scan(6); dr_scan($urandom); end
                default: begin ir_scan(4); dr_scan(32'($urandom_range(0, 15))); end
            endcase
        end

        ack_delay = 3;
        ir_scan(4); dr_scan(32'b0011);
        ir_scan(5); dr_scan(1);
        ir_scan(2); dr_scan($urandom);
        ack_hold = 1;
        ir_scan(3); dr_scan($urandom);
        tck(0, 0); tck(0, 0);
        check("busy req before trst", req, 1);
        #2 TRST = 1;
        #1;
        check("trst req", req, 0);
        check("trst run", run, 0);
        check("trst address", address, 0);
        @(negedge TCK);
        TRST = 0;
        ack_hold = 0;
        model_reset();
        tck(0, 0);
        dr_scan($urandom);
        repeat (4) tck(0, 0);

        check("scan queue drained", 64'(exp_len.size()), 0);
        check("bus queue drained", 64'(bus_addr.size()), 0);
        check("step pulses seen", 64'(exp_steps), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
